// File: rtl/field_extract_arbiter.sv
// Round-robin arbiter in front of one shared bit-field extractor:
// grant one requester, capture its payload, extract the field, hold the result until taken.
module field_extract_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_word,
  input  logic [N_REQ*5-1:0]      req_lsb,
  input  logic [N_REQ*6-1:0]      req_width,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2:0]              rsp_id,
  output logic [DATA_W-1:0]       rsp_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXTRACT = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_last_grant;
  logic [2:0]          r_id;
  logic [DATA_W-1:0]   r_word;
  logic [4:0]          r_lsb;
  logic [5:0]          r_width;
  logic                r_rsp_valid;
  logic [2:0]          r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;

  logic                w_found;
  logic [2:0]          w_grant;
  logic [DATA_W-1:0]   w_word;
  logic [4:0]          w_lsb;
  logic [5:0]          w_width;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_field;

  // Search starts just after the last winner and wraps; first valid wins.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && req_valid[i] && ((int'(r_last_grant) + k) % N_REQ == i)) begin
          w_found = 1'b1;
          w_grant = 3'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_word    = '0;
    w_lsb     = '0;
    w_width   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == 3'(i)) begin
        req_ready[i] = (r_state == S_IDLE) && w_found && !reset;
        w_word       = req_word[DATA_W*i +: DATA_W];
        w_lsb        = req_lsb[5*i +: 5];
        w_width      = req_width[6*i +: 6];
      end
    end
  end

  // Shifting all-ones by >= DATA_W yields zero, so widths of 32 and above
  // saturate to an all-ones mask and width 0 gives an empty mask.
  assign w_shifted = r_word >> r_lsb;
  assign w_mask    = ~({DATA_W{1'b1}} << r_width);
  assign w_field   = w_shifted & w_mask;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_EXTRACT;
      S_EXTRACT: w_state_nxt = S_RESPOND;
      S_RESPOND: if (rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 3'(N_REQ - 1);
      r_id         <= '0;
      r_word       <= '0;
      r_lsb        <= '0;
      r_width      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_word       <= w_word;
            r_lsb        <= w_lsb;
            r_width      <= w_width;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
          end
        end
        S_EXTRACT: begin
          r_rsp_data  <= w_field;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        S_RESPOND: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_field_extract_arbiter.sv
// Directed bench for field_extract_arbiter: arbitration order, extraction
// boundaries, response stall and mid-transaction reset.
module tb_field_extract_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_word;
  logic [N*5-1:0] req_lsb;
  logic [N*6-1:0] req_width;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2:0]     rsp_id;
  logic [31:0]    rsp_data;

  logic [31:0] word [N];
  logic [4:0]  lsb  [N];
  logic [5:0]  wid  [N];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_word[32*i +: 32] = word[i];
      req_lsb[5*i +: 5]    = lsb[i];
      req_width[6*i +: 6]  = wid[i];
    end
  end

  field_extract_arbiter #(.N_REQ(N), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_word  (req_word),
    .req_lsb   (req_lsb),
    .req_width (req_width),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Single-requester transaction from S_IDLE; returns what was observed.
  task automatic issue(input int i, input logic [31:0] w, input logic [4:0] l,
                       input logic [5:0] wd, output logic [3:0] rdy, output logic v,
                       output logic [2:0] id, output logic [31:0] d);
    word[i] = w;
    lsb[i] = l;
    wid[i] = wd;
    req_valid = 4'b0001 << i;
    #1;
    rdy = req_ready;
    step();
    req_valid = '0;
    step();
    v = rsp_valid;
    id = rsp_id;
    d = rsp_data;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b1111;
    step();
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready_gated got=%b exp=%b", req_ready, 4'b0000);
    else n_pass++;
    req_valid = '0;
    step();
    reset = 1'b0;
    #1;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
    else n_pass++;
    n_total++;
    if (rsp_id !== 3'd0) $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id);
    else n_pass++;
    n_total++;
    if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data got=%h exp=00000000", rsp_data);
    else n_pass++;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [3:0] rdy;
    logic v;
    logic [2:0] id;
    logic [31:0] d;
    issue(0, 32'hDEADBEEF, 5'd8, 6'd8, rdy, v, id, d);
    n_total++;
    if (rdy !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", rdy);
    else n_pass++;
    n_total++;
    if (v !== 1'b1) $display("FAIL single_valid got=%b exp=1", v);
    else n_pass++;
    n_total++;
    if (id !== 3'd0) $display("FAIL single_id got=%0d exp=0", id);
    else n_pass++;
    n_total++;
    if (d !== 32'h000000BE) $display("FAIL single_data got=%h exp=000000be", d);
    else n_pass++;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_done got=%b exp=0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) begin
      word[i] = 32'h11111111 * (i + 1);
      lsb[i] = 5'(4 * i);
      wid[i] = 6'd4;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp = k % N;
      n_total++;
      if (req_ready !== (4'b0001 << exp))
        $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'b0001 << exp);
      else n_pass++;
      step();
      step();
      n_total++;
      if ({rsp_valid, rsp_id, req_ready} !== {1'b1, 3'(exp), 4'b0000})
        $display("FAIL rr_rsp%0d got v=%b id=%0d rdy=%b exp v=1 id=%0d rdy=0000",
                 k, rsp_valid, rsp_id, req_ready, exp);
      else n_pass++;
      n_total++;
      if (rsp_data !== 32'(exp + 1)) $display("FAIL rr_data%0d got=%h exp=%h", k, rsp_data, exp + 1);
      else n_pass++;
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
  endtask

  task automatic test_boundaries();
    logic [3:0] rdy;
    logic v;
    logic [2:0] id;
    logic [31:0] d;
    logic [31:0] exp_d [4] = '{32'h0000000F, 32'h00000000, 32'hFFFFFFFF, 32'h01234567};
    logic [31:0] in_w  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    logic [4:0]  in_l  [4] = '{5'd28, 5'd28, 5'd0, 5'd4};
    logic [5:0]  in_wd [4] = '{6'd8, 6'd0, 6'd32, 6'd40};
    for (int t = 0; t < 4; t++) begin
      issue(2, in_w[t], in_l[t], in_wd[t], rdy, v, id, d);
      n_total++;
      if (rdy !== 4'b0100) $display("FAIL bound%0d_ready got=%b exp=0100", t, rdy);
      else n_pass++;
      n_total++;
      if ({v, id} !== {1'b1, 3'd2}) $display("FAIL bound%0d_id got v=%b id=%0d exp v=1 id=2", t, v, id);
      else n_pass++;
      n_total++;
      if (d !== exp_d[t]) $display("FAIL bound%0d_data got=%h exp=%h", t, d, exp_d[t]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    word[1] = 32'hA5A50F0F;
    lsb[1] = 5'd8;
    wid[1] = 6'd12;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0001;
    step();
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 3'd1, 32'h0000050F, 4'b0000})
        $display("FAIL stall_hold%0d got v=%b id=%0d d=%h rdy=%b exp v=1 id=1 d=0000050f rdy=0000",
                 c, rsp_valid, rsp_id, rsp_data, req_ready);
      else n_pass++;
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL stall_release got=%b exp=0", rsp_valid);
    else n_pass++;
  endtask

  // Runs right after test_stall, so last_grant is 1.
  task automatic test_fairness();
    word[3] = 32'h000000F0; lsb[3] = 5'd4; wid[3] = 6'd4;
    word[1] = 32'h12345678; lsb[1] = 5'd0; wid[1] = 6'd16;
    req_valid = 4'b1010;
    #1;
    n_total++;
    if (req_ready !== 4'b1000) $display("FAIL fair_first got=%b exp=1000", req_ready);
    else n_pass++;
    step();
    req_valid = 4'b0010;
    step();
    n_total++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 3'd3, 32'h0000000F})
      $display("FAIL fair_rsp3 got v=%b id=%0d d=%h exp v=1 id=3 d=0000000f", rsp_valid, rsp_id, rsp_data);
    else n_pass++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL fair_second got=%b exp=0010", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    step();
    n_total++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 3'd1, 32'h00005678})
      $display("FAIL fair_rsp1 got v=%b id=%0d d=%h exp v=1 id=1 d=00005678", rsp_valid, rsp_id, rsp_data);
    else n_pass++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    word[2] = 32'hCAFEF00D; lsb[2] = 5'd0; wid[2] = 6'd32;
    req_valid = 4'b0100;
    step();
    reset = 1'b1;
    req_valid = 4'b1111;
    step();
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", rsp_valid);
    else n_pass++;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL midrst_ready got=%b exp=0000", req_ready);
    else n_pass++;
    reset = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL midrst_noresp%0d got=%b exp=0", c, rsp_valid);
      else n_pass++;
    end
    req_valid = 4'b1111;
    #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL midrst_regrant got=%b exp=0001", req_ready);
    else n_pass++;
    req_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      word[i] = '0;
      lsb[i] = '0;
      wid[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_boundaries();
    test_stall();
    test_fairness();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
